// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, requester IDs and default port widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: a sole requester wins,
// on a tie the requester that was not granted last wins.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Winner selection with tie broken against the last grantee
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = REQ_LDR;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the CPU and the loader:
// round-robin grant, one mem_en strobe per transaction, one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    arb_state_t        state_r;
    logic              last_r;
    logic [2:0]        cnt_r;
    logic              pick_valid_s;
    logic              pick_winner_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_r),
        .valid  (pick_valid_s),
        .winner (pick_winner_s)
    );

    // Request fields of the current winner
    always_comb begin
        if (pick_winner_s == REQ_LDR) begin
            sel_wr_s    = wr1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_wr_s    = wr0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Arbitration FSM; the mem_* registers double as the request latch,
    // loaded at grant so they are already valid in the ACCESS cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= REQ_LDR;
            cnt_r     <= 3'd0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= {DATA_W{1'b0}};
            rdata1    <= {DATA_W{1'b0}};
            busy      <= 1'b0;
            owner     <= REQ_CPU;
        end else begin
            mem_en <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        owner     <= pick_winner_s;
                        last_r    <= pick_winner_s;
                        mem_en    <= 1'b1;
                        mem_wr    <= sel_wr_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= sel_wdata_s;
                        busy      <= 1'b1;
                        state_r   <= ST_ACCESS;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    cnt_r   <= LAT_LOAD;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        if (!mem_wr) begin
                            if (owner == REQ_LDR) begin
                                rdata1 <= mem_rdata;
                            end else begin
                                rdata0 <= mem_rdata;
                            end
                        end else begin
                            rdata0 <= rdata0;
                        end
                        if (owner == REQ_LDR) begin
                            ack1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                        end
                        state_r <= ST_ACK;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                ST_ACK: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: one arbiter with MEM_LAT=1 and one with
// MEM_LAT=3, each with a small latency-accurate memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        req0, req1, wr0, wr1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic        l1_ack0, l1_ack1, l1_mem_en, l1_mem_wr, l1_busy, l1_owner;
    logic [15:0] l1_rdata0, l1_rdata1, l1_mem_wdata, l1_rd;
    logic [9:0]  l1_mem_addr;
    logic        l3_ack0, l3_ack1, l3_mem_en, l3_mem_wr, l3_busy, l3_owner;
    logic [15:0] l3_rdata0, l3_rdata1, l3_mem_wdata, l3_p1, l3_p2, l3_p3;
    logic [9:0]  l3_mem_addr;

    int n_checks = 0;
    int n_errs   = 0;
    int n_en_l1 = 0, n_ack0_l1 = 0, n_ack1_l1 = 0;
    int n_ack0_l3 = 0, n_ack1_l3 = 0;
    int e_mark, a0_mark, a1_mark;
    logic own_log[$];
    logic ack_log[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst1), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(l1_ack0), .ack1(l1_ack1), .rdata0(l1_rdata0), .rdata1(l1_rdata1),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_rd), .busy(l1_busy), .owner(l1_owner)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst3), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(l3_ack0), .ack1(l3_ack1), .rdata0(l3_rdata0), .rdata1(l3_rdata1),
        .mem_en(l3_mem_en), .mem_wr(l3_mem_wr), .mem_addr(l3_mem_addr),
        .mem_wdata(l3_mem_wdata), .mem_rdata(l3_p3), .busy(l3_busy), .owner(l3_owner)
    );

    function automatic logic [15:0] mem_val(input logic [9:0] a);
        case (a)
            10'h005: mem_val = 16'hBEEF;
            10'h010: mem_val = 16'h1111;
            10'h020: mem_val = 16'h2222;
            default: mem_val = {6'h3C, a};
        endcase
    endfunction

    // Memory models: read data appears MEM_LAT cycles after the strobe
    always @(posedge clk) begin
        l1_rd <= l1_mem_en ? mem_val(l1_mem_addr) : 16'hDEAD;
        l3_p1 <= l3_mem_en ? mem_val(l3_mem_addr) : 16'hDEAD;
        l3_p2 <= l3_p1;
        l3_p3 <= l3_p2;
    end

    // Strobe and ack pulse counters
    always @(posedge clk) begin
        if (l1_mem_en) n_en_l1   <= n_en_l1 + 1;
        if (l1_ack0)   n_ack0_l1 <= n_ack0_l1 + 1;
        if (l1_ack1)   n_ack1_l1 <= n_ack1_l1 + 1;
        if (l3_ack0)   n_ack0_l3 <= n_ack0_l3 + 1;
        if (l3_ack1)   n_ack1_l3 <= n_ack1_l3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 10'h000; addr1 = 10'h000; wdata0 = 16'h0000; wdata1 = 16'h0000;

        #2;
        check("rst_busy",  32'(l1_busy), 32'd0);
        check("rst_owner", 32'(l1_owner), 32'd0);
        check("rst_en",    32'(l1_mem_en), 32'd0);
        check("rst_wr",    32'(l1_mem_wr), 32'd0);
        check("rst_addr",  32'(l1_mem_addr), 32'd0);
        check("rst_wdata", 32'(l1_mem_wdata), 32'd0);
        check("rst_acks",  32'({l1_ack1, l1_ack0}), 32'd0);
        check("rst_rdata", 32'({l1_rdata1, l1_rdata0}), 32'd0);
        tick(); tick();
        rst1 = 1'b0;
        tick();

        // CPU read, sole requester
        req0 = 1'b1; addr0 = 10'h005; wr0 = 1'b0;
        e_mark = n_en_l1; a1_mark = n_ack1_l1;
        tick();
        check("t1_en",    32'(l1_mem_en), 32'd1);
        check("t1_addr",  32'(l1_mem_addr), 32'h005);
        check("t1_wr",    32'(l1_mem_wr), 32'd0);
        check("t1_owner", 32'(l1_owner), 32'd0);
        check("t1_busy",  32'(l1_busy), 32'd1);
        req0 = 1'b0;
        tick();
        check("t1_c2_en",   32'(l1_mem_en), 32'd0);
        check("t1_c2_ack0", 32'(l1_ack0), 32'd0);
        tick();
        check("t1_ack0",  32'(l1_ack0), 32'd1);
        check("t1_ack1",  32'(l1_ack1), 32'd0);
        check("t1_rdata", 32'(l1_rdata0), 32'hBEEF);
        tick();
        check("t1_ack_end", 32'(l1_ack0), 32'd0);
        check("t1_idle",    32'(l1_busy), 32'd0);
        check("t1_en_cnt",  32'(n_en_l1 - e_mark), 32'd1);
        check("t1_no_ack1", 32'(n_ack1_l1 - a1_mark), 32'd0);

        // Address changes during WAIT must not reach the port
        req0 = 1'b1; addr0 = 10'h010;
        tick();
        check("t6_addr", 32'(l1_mem_addr), 32'h010);
        req0 = 1'b0;
        tick();
        addr0 = 10'h020;
        tick();
        check("t6_addr_hold", 32'(l1_mem_addr), 32'h010);
        check("t6_ack0",      32'(l1_ack0), 32'd1);
        check("t6_rdata",     32'(l1_rdata0), 32'h1111);
        tick();

        // Simultaneous requests after reset: CPU first, loader next
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h010; addr1 = 10'h020;
        tick();
        check("t2_owner0", 32'(l1_owner), 32'd0);
        check("t2_en0",    32'(l1_mem_en), 32'd1);
        check("t2_addr0",  32'(l1_mem_addr), 32'h010);
        req0 = 1'b0;
        tick(); tick();
        check("t2_ack0",   32'(l1_ack0), 32'd1);
        check("t2_rdata0", 32'(l1_rdata0), 32'h1111);
        tick();
        check("t2_gap_en", 32'(l1_mem_en), 32'd0);
        tick();
        check("t2_en1",    32'(l1_mem_en), 32'd1);
        check("t2_owner1", 32'(l1_owner), 32'd1);
        check("t2_addr1",  32'(l1_mem_addr), 32'h020);
        req1 = 1'b0;
        tick(); tick();
        check("t2_ack1",   32'(l1_ack1), 32'd1);
        check("t2_rdata1", 32'(l1_rdata1), 32'h2222);
        tick();

        // Both requests held: grants and acks alternate
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (l1_mem_en) own_log.push_back(l1_owner);
            if (l1_ack0) ack_log.push_back(1'b0);
            if (l1_ack1) ack_log.push_back(1'b1);
            if (own_log.size() >= 4) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            if (own_log.size() >= 4 && !l1_busy) break;
        end
        check("t3_grants", 32'(own_log.size()), 32'd4);
        check("t3_acks",   32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_owner%0d", i),
                  32'((i < own_log.size()) ? {1'b0, own_log[i]} : 2'd2), 32'(i % 2));
            check($sformatf("t3_ack%0d", i),
                  32'((i < ack_log.size()) ? {1'b0, ack_log[i]} : 2'd2), 32'(i % 2));
        end
        check("t3_idle", 32'(l1_busy), 32'd0);
        tick();

        // Loader write leaves rdata1 untouched
        req1 = 1'b1; wr1 = 1'b1; addr1 = 10'h3FF; wdata1 = 16'h1234;
        tick();
        check("t4_en",    32'(l1_mem_en), 32'd1);
        check("t4_wr",    32'(l1_mem_wr), 32'd1);
        check("t4_addr",  32'(l1_mem_addr), 32'h3FF);
        check("t4_wdata", 32'(l1_mem_wdata), 32'h1234);
        check("t4_owner", 32'(l1_owner), 32'd1);
        req1 = 1'b0; wr1 = 1'b0;
        tick(); tick();
        check("t4_ack1",   32'(l1_ack1), 32'd1);
        check("t4_ack0",   32'(l1_ack0), 32'd0);
        check("t4_rdata1", 32'(l1_rdata1), 32'h2222);
        tick();

        // MEM_LAT=3: latency, then reset in the middle of WAIT
        rst3 = 1'b0;
        tick();
        req1 = 1'b1; addr1 = 10'h005; wr1 = 1'b0;
        tick();
        check("t5_en",    32'(l3_mem_en), 32'd1);
        check("t5_owner", 32'(l3_owner), 32'd1);
        req1 = 1'b0;
        tick(); tick(); tick();
        check("t5_no_early_ack", 32'(l3_ack1), 32'd0);
        tick();
        check("t5_ack1",   32'(l3_ack1), 32'd1);
        check("t5_rdata1", 32'(l3_rdata1), 32'hBEEF);
        tick(); tick();
        req0 = 1'b1; addr0 = 10'h010; wdata0 = 16'hCAFE;
        tick();
        check("t5_en0",   32'(l3_mem_en), 32'd1);
        check("t5_addr0", 32'(l3_mem_addr), 32'h010);
        tick(); tick();
        a0_mark = n_ack0_l3; a1_mark = n_ack1_l3;
        rst3 = 1'b1;
        #1;
        check("t5_rst_busy",  32'(l3_busy), 32'd0);
        check("t5_rst_owner", 32'(l3_owner), 32'd0);
        check("t5_rst_en",    32'(l3_mem_en), 32'd0);
        check("t5_rst_wr",    32'(l3_mem_wr), 32'd0);
        check("t5_rst_addr",  32'(l3_mem_addr), 32'd0);
        check("t5_rst_wdata", 32'(l3_mem_wdata), 32'd0);
        check("t5_rst_acks",  32'({l3_ack1, l3_ack0}), 32'd0);
        check("t5_rst_rdata", 32'({l3_rdata1, l3_rdata0}), 32'd0);
        tick(); tick();
        req1 = 1'b1;
        rst3 = 1'b0;
        tick();
        check("t5_tie_en",    32'(l3_mem_en), 32'd1);
        check("t5_tie_owner", 32'(l3_owner), 32'd0);
        check("t5_tie_addr",  32'(l3_mem_addr), 32'h010);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!l3_busy) break;
        end
        check("t5_idle",      32'(l3_busy), 32'd0);
        check("t5_ack0_once", 32'(n_ack0_l3 - a0_mark), 32'd1);
        check("t5_no_ack1",   32'(n_ack1_l3 - a1_mark), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single 16-bit data / 10-bit address memory port. It shares that port between the accumulator CPU (requester 0) and a program loader / DMA engine (requester 1). Each granted request becomes one fixed-latency memory transaction. Grants use round-robin priority, and completion is signalled with a one-cycle ack per requester.

## Interface
Parameters:
- ADDR_W, 10: memory address width
- DATA_W, 16: memory data width
- MEM_LAT, 1: cycles from the mem_en cycle until mem_rdata is valid; legal range 1..7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req0 / req1  in  1  transaction request from requester 0 / 1
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  request address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read result, valid from ack cycle, held until next read by same requester
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_wr  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE
- owner  out  1  ID of the current or last granted requester

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT, ACK. All outputs are registered.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner, latch its wr/addr/wdata, set owner, and go to ACCESS.
- Round-robin rule:
  - A sole requester always wins.
  - If both requesters are high, the one not equal to `last` wins.
  - `last` updates at each grant.
- ACCESS:
  - mem_en = 1, with mem_wr/mem_addr/mem_wdata taken from the latched values.
  - Go to WAIT.
- WAIT:
  - A down-counter is loaded with MEM_LAT-1 on entry to WAIT.
  - WAIT lasts MEM_LAT cycles.
  - At the edge ending the last WAIT cycle, mem_rdata is captured into rdata[owner] (reads only; writes leave rdata unchanged).
  - Go to ACK.
- ACK:
  - ack[owner] = 1 for exactly one cycle.
  - req is ignored in this cycle.
  - Go to IDLE.
  - A requester that holds req high past ACK is treated as issuing a new request.
- Latched request fields are immune to input changes after the grant.
- Dropping req after the grant does not abort the transaction; the ack still pulses.
- mem_wr, mem_addr and mem_wdata hold their values outside ACCESS. They are don't-care when mem_en = 0.
- Reset values (asynchronous, immediate):
  - state = IDLE
  - mem_en = mem_wr = 0
  - mem_addr = mem_wdata = 0
  - ack0 = ack1 = 0
  - rdata0 = rdata1 = 0
  - busy = 0, owner = 0
  - last = 1, so requester 0 wins the first tie
- Reset during ACCESS/WAIT/ACK abandons the transaction and no ack is issued. Whether a write already strobed completes is the memory's concern.

## Timing
- Request sampled at edge E0 (IDLE):
  - ACCESS in cycle 1
  - WAIT in cycles 2..MEM_LAT+1
  - ACK in cycle MEM_LAT+2
  - IDLE in cycle MEM_LAT+3
- Request-to-ack latency is MEM_LAT+2 cycles. Read and write latency are identical.
- Back-to-back transactions: the next ACCESS occurs at cycle MEM_LAT+4 at the earliest. The throughput period is MEM_LAT+3 cycles.
- Fairness: with both requests held continuously, grants strictly alternate. Worst-case wait is one full transaction.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, ACK=2'd3)
  - requester IDs (REQ_CPU=0, REQ_LDR=1)
  - default ADDR_W/DATA_W
- One sub-module, rr_pick2: combinational 2-way round-robin selector.
  - Inputs: req0, req1, last.
  - Outputs: valid, winner.
- The FSM, latches and counter live in mem_port_arbiter.

## Test plan
- CPU read, MEM_LAT=1, only req0=1, addr0=0x005, memory model returns 0xBEEF:
  - one mem_en cycle with mem_addr=0x005, mem_wr=0
  - ack0 three cycles after sampling edge, rdata0=0xBEEF
  - ack1 never asserts
- After reset, req0 and req1 rise together:
  - CPU is served first (owner=0), then loader (owner=1)
  - the loader's mem_en comes two cycles after ack0
- Both requests held for four transactions: owner sequence 0,1,0,1 and ack pulses alternate.
- Loader write, addr1=0x3FF, wdata1=0x1234, wr1=1:
  - mem_wr=1, mem_wdata=0x1234 during mem_en
  - ack1 pulses; rdata1 keeps its prior value
- MEM_LAT=3, rst asserted mid-WAIT:
  - all outputs go to reset values without a clock edge; no ack
  - after release with both requests high, requester 0 wins
- addr0 changed from 0x010 to 0x020 during WAIT: mem_addr stays 0x010 and the transaction completes normally.
